// File: rtl/zindan_pkg.sv
// Shared definitions for the ALU writeback stage: default widths, the
// hard-wired zero register index, the chaos-trap data pattern and the
// encoding used to classify the entry at the head of the writeback FIFO.
package zindan_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  localparam int          ZERO_REG      = 0;
  localparam logic [31:0] CHAOS_PATTERN = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    KIND_WRITE  = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_DROP   = 2'd2
  } head_kind_e;

  // Branches never write a register; non-branch writes to x0 are discarded.
  function automatic head_kind_e classify_head(input logic is_branch,
                                               input logic rd_is_zero);
    if (is_branch)
      return KIND_BRANCH;
    else if (rd_is_zero)
      return KIND_DROP;
    else
      return KIND_WRITE;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for the writeback stage. The caller qualifies push
// (never when full) and pop (never when empty); the head entry is always
// visible on rd_data so the consumer can decode it without a read latency.
// Storage is not reset: only pointers and occupancy carry meaning after reset.
module wb_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Pointer and occupancy state; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage, written at the write pointer on an accepted push.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == CW'(0));

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage. Queues ALU results in a small FIFO and drains the head
// entry to the register-file write port (valid/ready), to a one-cycle branch
// resolution pulse, or silently for writes to x0. Counts every retired entry.
// Optional feature macro: ZINDAN_CHAOS_TRAP_EN adds the sticky chaos_trap
// output, set when a register write of 32'hDEADBEEF retires.
module alu_wb_stage
  import zindan_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_result,
  input  logic                   in_zero,
  input  logic [REG_AW-1:0]      in_rd,
  input  logic                   in_is_branch,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [REG_AW-1:0]      wb_addr,
  output logic [DATA_W-1:0]      wb_data,
  output logic                   branch_valid,
  output logic                   branch_taken,
  output logic [31:0]            retire_cnt,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef ZINDAN_CHAOS_TRAP_EN
  ,
  output logic                   chaos_trap
`endif
);

  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = DATA_W + REG_AW + 2;

  // Entry layout, MSB first: {is_branch, zero, rd, result}
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               ready_en;

  logic [DATA_W-1:0]  head_result;
  logic [REG_AW-1:0]  head_rd;
  logic               head_zero;
  logic               head_br;
  head_kind_e         head_kind;

  assign push_entry = {in_is_branch, in_zero, in_rd, in_result};

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (push_entry),
    .pop     (pop),
    .rd_data (head_entry),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Holds off acceptance until the first clock edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ready_en <= 1'b0;
    else
      ready_en <= 1'b1;
  end

  // Depends only on registered state, never on wb_ready, so a full FIFO
  // blocks a push even in a cycle where the head pops.
  assign in_ready = ready_en && (fifo_count < CW'(DEPTH));
  assign push     = in_valid && in_ready;

  assign head_result = head_entry[DATA_W-1:0];
  assign head_rd     = head_entry[DATA_W +: REG_AW];
  assign head_zero   = head_entry[DATA_W + REG_AW];
  assign head_br     = head_entry[DATA_W + REG_AW + 1];
  assign head_kind   = classify_head(head_br, head_rd == REG_AW'(ZERO_REG));

  // Drive the write port, branch pulse and pop decision from the head entry.
  always_comb begin
    wb_valid     = 1'b0;
    wb_addr      = head_rd;
    wb_data      = head_result;
    branch_valid = 1'b0;
    branch_taken = 1'b0;
    pop          = 1'b0;
    if (!fifo_empty) begin
      case (head_kind)
        KIND_WRITE: begin
          wb_valid = 1'b1;
          pop      = wb_ready;
        end
        KIND_BRANCH: begin
          branch_valid = 1'b1;
          branch_taken = head_zero;
          pop          = 1'b1;
        end
        default: begin
          pop = 1'b1;
        end
      endcase
    end
  end

  // Free-running count of retired entries of every kind; wraps at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retire_cnt <= 32'd0;
    else if (pop)
      retire_cnt <= retire_cnt + 32'd1;
  end

`ifdef ZINDAN_CHAOS_TRAP_EN
  // Sticky flag: set when a register write of the chaos pattern retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      chaos_trap <= 1'b0;
    else if (pop && (head_kind == KIND_WRITE) && (head_result == DATA_W'(CHAOS_PATTERN)))
      chaos_trap <= 1'b1;
  end
`endif

endmodule
